riscv_trace_arb: RTL



---
 rtl/riscv_trace_arb_pkg.sv | 18 +
 rtl/riscv_trace_fifo.sv | 48 ++++
 rtl/riscv_trace_arb.sv | 117 +++++++++++
 3 files changed

// File: rtl/riscv_trace_arb_pkg.sv
// Shared definitions for the retire-trace arbiter: trace entry layout and a packing helper.
// The optional counters are enabled with the RISCV_TRACE_ARB_CNT_EN macro (see riscv_trace_arb).
package riscv_trace_arb_pkg;

    localparam int TRACE_ENTRY_W   = 64;
    localparam int TRACE_PC_LSB    = 32;
    localparam int TRACE_INSTR_LSB = 0;

    function automatic logic [TRACE_ENTRY_W-1:0] pack_entry(input logic [31:0] pc,
                                                            input logic [31:0] instr);
        logic [TRACE_ENTRY_W-1:0] e;
        e = '0;
        e[TRACE_PC_LSB +: 32]    = pc;
        e[TRACE_INSTR_LSB +: 32] = instr;
        return e;
    endfunction

endpackage

// File: rtl/riscv_trace_fifo.sv
// DEPTH-entry trace buffer with a 2-entry write port and a 1-entry read port.
// The caller guarantees i_push_n never exceeds free space and i_pop only fires when non-empty.
module riscv_trace_fifo
    import riscv_trace_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [1:0]               i_push_n,
    input  logic [TRACE_ENTRY_W-1:0] i_data0,
    input  logic [TRACE_ENTRY_W-1:0] i_data1,
    input  logic                     i_pop,
    output logic [PTR_W:0]           o_count,
    output logic [TRACE_ENTRY_W-1:0] o_head
);

    logic [TRACE_ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W:0]           r_count;
    logic [PTR_W-1:0]         w_wr_ptr1;

    assign w_wr_ptr1 = r_wr_ptr + 1'b1;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(i_push_n);
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop);
            r_count  <= r_count + (PTR_W+1)'(i_push_n) - (PTR_W+1)'(i_pop);
        end
    end

    // Storage needs no reset: the head is masked by the owner whenever count is zero.
    always_ff @(posedge clk_i) begin
        if (i_push_n != 2'd0) r_mem[r_wr_ptr]  <= i_data0;
        if (i_push_n == 2'd2) r_mem[w_wr_ptr1] <= i_data1;
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/riscv_trace_arb.sv
// Serialises the two retire lanes onto one trace port, with backpressure and sticky drop flag.
// Define RISCV_TRACE_ARB_CNT_EN to add drop_cnt_o / retire_cnt_o statistics outputs.
module riscv_trace_arb
    import riscv_trace_arb_pkg::*;
#(
    parameter int DEPTH = 8
`ifdef RISCV_TRACE_ARB_CNT_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        lane0_valid_i,
    input  logic [31:0] lane0_pc_i,
    input  logic [31:0] lane0_instr_i,
    input  logic        lane1_valid_i,
    input  logic [31:0] lane1_pc_i,
    input  logic [31:0] lane1_instr_i,
    output logic        stall_o,
    output logic        trace_valid_o,
    output logic [31:0] trace_pc_o,
    output logic [31:0] trace_instr_o,
    input  logic        trace_ready_i,
    output logic        overflow_o
`ifdef RISCV_TRACE_ARB_CNT_EN
    , output logic [CNT_W-1:0] drop_cnt_o
    , output logic [31:0]      retire_cnt_o
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]            w_count;
    logic [CW-1:0]            w_free;
    logic [1:0]               w_demand;
    logic [1:0]               w_accept;
    logic [1:0]               w_drop;
    logic                     w_pop;
    logic [TRACE_ENTRY_W-1:0] w_slot0;
    logic [TRACE_ENTRY_W-1:0] w_slot1;
    logic [TRACE_ENTRY_W-1:0] w_head;
    logic                     r_overflow;

    // Free space comes only from the registered count; a pop this cycle gives no credit.
    assign w_free = CW'(DEPTH) - w_count;

    always_comb begin
        w_demand = 2'd0;
        if (enable_i) begin
            w_demand = {1'b0, lane0_valid_i} + {1'b0, lane1_valid_i};
        end
        if (w_free >= CW'(w_demand)) begin
            w_accept = w_demand;
        end else begin
            w_accept = w_free[1:0];
        end
        w_drop = w_demand - w_accept;
    end

    // A lone lane1 retire takes the first slot; with both valid lane0 goes first.
    assign w_slot0 = lane0_valid_i ? pack_entry(lane0_pc_i, lane0_instr_i)
                                   : pack_entry(lane1_pc_i, lane1_instr_i);
    assign w_slot1 = pack_entry(lane1_pc_i, lane1_instr_i);

    assign trace_valid_o = (w_count != '0);
    assign w_pop         = trace_valid_o && trace_ready_i;

    riscv_trace_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .i_push_n (w_accept),
        .i_data0  (w_slot0),
        .i_data1  (w_slot1),
        .i_pop    (w_pop),
        .o_count  (w_count),
        .o_head   (w_head)
    );

    assign trace_pc_o    = trace_valid_o ? w_head[TRACE_PC_LSB +: 32]    : 32'd0;
    assign trace_instr_o = trace_valid_o ? w_head[TRACE_INSTR_LSB +: 32] : 32'd0;
    assign stall_o       = (w_free < CW'(2));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop != 2'd0) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_o = r_overflow;

`ifdef RISCV_TRACE_ARB_CNT_EN
    logic [CNT_W-1:0] r_drop_cnt;
    logic [31:0]      r_retire_cnt;
    logic [CNT_W:0]   w_drop_sum;

    assign w_drop_sum = {1'b0, r_drop_cnt} + (CNT_W+1)'(w_drop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_drop_cnt   <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_drop_cnt   <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
            r_retire_cnt <= r_retire_cnt + 32'(w_accept);
        end
    end

    assign drop_cnt_o   = r_drop_cnt;
    assign retire_cnt_o = r_retire_cnt;
`endif

endmodule
